// File: rtl/mult_div_if.sv
// Command/operand/result bundle between the control unit and the multiply/divide unit.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic [1:0]       mult_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (output mult_div, a, b, input hi, lo, busy, done, div0);
    modport slave  (input mult_div, a, b, output hi, lo, busy, done, div0);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / restoring divide, one iteration per cycle, results into HI/LO.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    mult_div_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDz} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q;
    logic               is_div_q, res_neg_q, rem_neg_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, div0_q;

    logic               cmd_mul, cmd_div;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_neg;

    assign cmd_mul = (bus.mult_div == 2'b01);
    assign cmd_div = (bus.mult_div == 2'b10);
    assign abs_a   = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b   = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // Multiply: add multiplicand into the upper half with carry, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: acc holds {rem, quo}; a borrow out of the trial subtract means restore.
    assign div_shift = {acc_q[2*WIDTH-2:0], 1'b0};
    assign div_diff  = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, mcand_q};
    assign div_next  = div_diff[WIDTH] ? div_shift
                                       : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    assign prod_neg  = -acc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cmd_mul) begin
                    state_d = StCalc;
                end else if (cmd_div) begin
                    state_d = (bus.b == '0) ? StDz : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            StDz:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            done_q <= (state_q == StFix);
            div0_q <= (state_q == StDz);
            case (state_q)
                StIdle: begin
                    if (state_d == StCalc) begin
                        is_div_q  <= cmd_div;
                        res_neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        rem_neg_q <= bus.a[WIDTH-1];
                        cnt_q     <= '0;
                        mcand_q   <= cmd_div ? abs_b : abs_a;
                        acc_q     <= {{WIDTH{1'b0}}, (cmd_div ? abs_a : abs_b)};
                    end
                end
                StCalc: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                StFix: begin
                    if (is_div_q) begin
                        lo_q <= res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_q <= rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end else begin
                        {hi_q, lo_q} <= res_neg_q ? prod_neg : acc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, expected results queued at issue time.
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    typedef struct {
        bit          dz;
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: every done/div0 pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && (bus.done || bus.div0)) begin
            check("done_div0_exclusive", 64'(bus.done & bus.div0), 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {62'd0, bus.done, bus.div0}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {62'd0, bus.done, bus.div0}, e.dz ? 64'd1 : 64'd2);
                check("latency_cycle", 64'(cyc), 64'(e.due));
                check("hi", 64'(bus.hi), 64'(e.hi));
                check("lo", 64'(bus.lo), 64'(e.lo));
            end
        end
    end

    task automatic start_op(input logic [1:0] cmd, input logic [31:0] av, input logic [31:0] bv,
                            input bit push, input bit dz,
                            input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        @(negedge clock);
        if (push) begin
            e.dz  = dz;
            e.due = cyc + (dz ? 2 : 34);
            e.hi  = eh;
            e.lo  = el;
            sb.push_back(e);
        end
        bus.mult_div = cmd;
        bus.a        = av;
        bus.b        = bv;
        @(posedge clock);
        #1;
        bus.mult_div = 2'b00;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0) break;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] cmd, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el);
        start_op(cmd, av, bv, 1'b1, 1'b0, eh, el);
        drain();
    endtask

    initial begin
        bus.mult_div = 2'b00;
        bus.a        = '0;
        bus.b        = '0;
        repeat (3) @(negedge clock);
        check("reset_hi",   64'(bus.hi),   64'd0);
        check("reset_lo",   64'(bus.lo),   64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_div0", 64'(bus.div0), 64'd0);
        reset = 1'b0;

        start_op(2'b01, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        check("busy_after_start", 64'(bus.busy), 64'd1);
        drain();
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // 59 / 6 = 9 rem 5 preloads HI/LO for the divide-by-zero case.
        run_op(2'b10, 32'd59, 32'd6, 32'd5, 32'd9);
        start_op(2'b10, 32'd1234, 32'd0, 1'b1, 1'b1, 32'd5, 32'd9);
        check("dz_busy_first_cycle", 64'(bus.busy), 64'd1);
        @(posedge clock);
        #1;
        check("dz_busy_released", 64'(bus.busy), 64'd0);
        drain();
        repeat (40) @(negedge clock);
        check("dz_hi_kept", 64'(bus.hi), 64'd5);
        check("dz_lo_kept", 64'(bus.lo), 64'd9);

        // A DIV arriving mid-MULT is dropped; operand changes after start are ignored.
        start_op(2'b01, 32'd1234, 32'hFFFF_FFC8, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFE_F210);
        repeat (10) @(posedge clock);
        #1;
        bus.mult_div = 2'b10;
        bus.a        = 32'd50;
        bus.b        = 32'd3;
        @(posedge clock);
        #1;
        bus.mult_div = 2'b00;
        drain();
        repeat (40) @(negedge clock);

        // Reset mid-DIV: no done is scored, so any pulse is flagged by the monitor.
        start_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_hi",   64'(bus.hi),   64'd0);
        check("midreset_lo",   64'(bus.lo),   64'd0);
        check("midreset_busy", 64'(bus.busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("midreset_no_pulse_hi", 64'(bus.hi), 64'd0);
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
        repeat (5) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
